// File: rtl/rb_steer_pipe.sv
// rb_steer_pipe: row-buffer steering stage.
// Accepts one column of RB_COUNT row-buffer pixels per beat and rotates the
// lanes so that lane 0 always carries the oldest row. The rotation pointer
// is tracked internally from column/row counting and resyncs on s_sof.
// The output is a single registered stage with valid/ready handshaking and
// start-of-frame, start-of-line and end-of-line markers.
module rb_steer_pipe #(
    parameter int PIXEL_BITS  = 8,
    parameter int KERNEL_SIZE = 9,
    parameter int CHANNELS    = 1,
    parameter int IMG_WIDTH   = 640,
    parameter int ROT_DIR     = 0,
    localparam int RB_COUNT   = KERNEL_SIZE - 1,
    localparam int LW         = CHANNELS * PIXEL_BITS,
    localparam int DW         = RB_COUNT * LW,
    localparam int PW         = $clog2(RB_COUNT),
    localparam int CW         = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_sof,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_sof,
    output logic          m_sol,
    output logic          m_eol,
    output logic [PW-1:0] rot_idx
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(RB_COUNT - 1);

    logic [CW-1:0] col;
    logic [PW-1:0] ptr;
    logic          xfer;
    logic [CW-1:0] col_e;
    logic [PW-1:0] ptr_e;
    logic          col_at_last;
    logic [CW-1:0] col_nxt;
    logic [PW-1:0] ptr_nxt;
    logic [DW-1:0] rot_data;

    // Source lane for output lane i when the pointer is p. Both arguments are
    // loop constants at the call site, so this folds away to wiring.
    function automatic int src_lane(input int i, input int p);
        if (ROT_DIR == 0)
            return (i + p) % RB_COUNT;
        else
            return (i - p + RB_COUNT) % RB_COUNT;
    endfunction

    // A new beat may enter whenever the output register is empty or draining.
    assign s_ready = !m_valid || m_ready;
    assign xfer    = s_valid && s_ready;

    // Effective position of the incoming beat; s_sof forces a resync to the
    // top-left of the frame regardless of where the counters currently are.
    always_comb begin
        col_e = col;
        ptr_e = ptr;
        if (s_sof) begin
            col_e = '0;
            ptr_e = '0;
        end
    end

    // Next counter values. The pointer wraps by explicit compare so it never
    // leaves 0..RB_COUNT-1 even when RB_COUNT is not a power of two.
    always_comb begin
        col_at_last = (col_e == COL_LAST);
        col_nxt     = col_e;
        ptr_nxt     = ptr_e;
        if (col_at_last) begin
            col_nxt = '0;
            if (ptr_e == PTR_LAST)
                ptr_nxt = '0;
            else
                ptr_nxt = ptr_e + PW'(1);
        end else begin
            col_nxt = col_e + CW'(1);
        end
    end

    // Lane rotation: one RB_COUNT-way mux per output lane, selected by ptr_e.
    // All channels of a lane move together as a single LW-bit unit.
    always_comb begin
        rot_data = '0;
        for (int i = 0; i < RB_COUNT; i++) begin
            for (int p = 0; p < RB_COUNT; p++) begin
                if (ptr_e == PW'(p))
                    rot_data[i*LW +: LW] = s_data[src_lane(i, p)*LW +: LW];
            end
        end
    end

    // Column and row-pointer counters; they only move on an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            ptr <= '0;
        end else if (xfer) begin
            col <= col_nxt;
            ptr <= ptr_nxt;
        end
    end

    // Output valid: set by a transfer, cleared when drained with nothing new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            m_valid <= 1'b0;
        else if (xfer)
            m_valid <= 1'b1;
        else if (m_ready)
            m_valid <= 1'b0;
    end

    // Output payload and markers; captured only on a transfer so they hold
    // stable under backpressure and never pick up idle-cycle input values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data <= '0;
            m_sof  <= 1'b0;
            m_sol  <= 1'b0;
            m_eol  <= 1'b0;
        end else if (xfer) begin
            m_data <= rot_data;
            m_sof  <= s_sof;
            m_sol  <= (col_e == '0);
            m_eol  <= col_at_last;
        end
    end

    assign rot_idx = ptr;

endmodule

// File: tb/tb_rb_steer_pipe.sv
// Bench for rb_steer_pipe: three instances (8 lanes forward, 8 lanes reverse,
// 3 lanes x 3 channels with a one-pixel row) driven by shared handshakes and
// compared against a row/column reference model.
module tb_rb_steer_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, s_valid, s_sof, m_ready;
    logic [63:0] d0;
    logic [71:0] d2;

    logic        sr0, mv0, msof0, msol0, meol0;
    logic [63:0] md0;
    logic [2:0]  ri0;
    logic        sr1, mv1, msof1, msol1, meol1;
    logic [63:0] md1;
    logic [2:0]  ri1;
    logic        sr2, mv2, msof2, msol2, meol2;
    logic [71:0] md2;
    logic [1:0]  ri2;

    rb_steer_pipe #(.PIXEL_BITS(8), .KERNEL_SIZE(9), .CHANNELS(1), .IMG_WIDTH(4), .ROT_DIR(0)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr0), .s_data(d0), .s_sof(s_sof),
        .m_valid(mv0), .m_ready(m_ready), .m_data(md0), .m_sof(msof0), .m_sol(msol0),
        .m_eol(meol0), .rot_idx(ri0));

    rb_steer_pipe #(.PIXEL_BITS(8), .KERNEL_SIZE(9), .CHANNELS(1), .IMG_WIDTH(4), .ROT_DIR(1)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr1), .s_data(d0), .s_sof(s_sof),
        .m_valid(mv1), .m_ready(m_ready), .m_data(md1), .m_sof(msof1), .m_sol(msol1),
        .m_eol(meol1), .rot_idx(ri1));

    rb_steer_pipe #(.PIXEL_BITS(8), .KERNEL_SIZE(4), .CHANNELS(3), .IMG_WIDTH(1), .ROT_DIR(0)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr2), .s_data(d2), .s_sof(s_sof),
        .m_valid(mv2), .m_ready(m_ready), .m_data(md2), .m_sof(msof2), .m_sol(msol2),
        .m_eol(meol2), .rot_idx(ri2));

    int checks = 0;
    int errors = 0;

    // Reference model state: position in the frame as plain column/row numbers.
    int          col, row, col2, row2;
    bit          ev, esof, esol, eeol, esol2, eeol2;
    logic [63:0] ed0, ed1;
    logic [71:0] ed2;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Out lane i takes in lane (i+p) mod r (dir 0) or (i-p) mod r (dir 1).
    function automatic logic [127:0] rot(input logic [127:0] d, input int r, input int lw,
                                         input int p, input int dir);
        logic [127:0] res;
        int src;
        res = '0;
        for (int i = 0; i < r; i++) begin
            src = (dir == 0) ? (i + p) % r : (i - p + r) % r;
            for (int b = 0; b < lw; b++) res[i*lw + b] = d[src*lw + b];
        end
        return res;
    endfunction

    task automatic model_reset();
        ev = 0; col = 0; row = 0; col2 = 0; row2 = 0;
    endtask

    task automatic check_outputs();
        chk("m_valid0", 128'(mv0), 128'(ev));
        chk("m_valid1", 128'(mv1), 128'(ev));
        chk("m_valid2", 128'(mv2), 128'(ev));
        chk("rot_idx0", 128'(ri0), 128'(row % 8));
        chk("rot_idx1", 128'(ri1), 128'(row % 8));
        chk("rot_idx2", 128'(ri2), 128'(row2 % 3));
        if (ev) begin
            chk("m_data0", 128'(md0), 128'(ed0));
            chk("m_data1", 128'(md1), 128'(ed1));
            chk("m_data2", 128'(md2), 128'(ed2));
            chk("m_sof0", 128'(msof0), 128'(esof));
            chk("m_sol0", 128'(msol0), 128'(esol));
            chk("m_eol0", 128'(meol0), 128'(eeol));
            chk("m_sof1", 128'(msof1), 128'(esof));
            chk("m_eol1", 128'(meol1), 128'(eeol));
            chk("m_sof2", 128'(msof2), 128'(esof));
            chk("m_sol2", 128'(msol2), 128'(esol2));
            chk("m_eol2", 128'(meol2), 128'(eeol2));
        end
    endtask

    // One clock: check s_ready, advance the model across the edge, check outputs.
    task automatic tick();
        bit rdy;
        int ce, re;
        #1;
        rdy = !ev || m_ready;
        chk("s_ready0", 128'(sr0), 128'(rdy));
        chk("s_ready1", 128'(sr1), 128'(rdy));
        chk("s_ready2", 128'(sr2), 128'(rdy));
        @(posedge clk);
        if (s_valid && rdy) begin
            ce = s_sof ? 0 : col;
            re = s_sof ? 0 : row;
            ed0 = 64'(rot(128'(d0), 8, 8, re % 8, 0));
            ed1 = 64'(rot(128'(d0), 8, 8, re % 8, 1));
            esof = s_sof;
            esol = (ce == 0);
            eeol = (ce == 3);
            if (ce == 3) begin col = 0; row = re + 1; end
            else begin col = ce + 1; row = re; end
            ce = s_sof ? 0 : col2;
            re = s_sof ? 0 : row2;
            ed2 = 72'(rot(128'(d2), 3, 24, re % 3, 0));
            esol2 = (ce == 0);
            eeol2 = (ce == 0);
            col2 = 0; row2 = re + 1;
            ev = 1;
        end else if (m_ready) begin
            ev = 0;
        end
        #1;
        check_outputs();
    endtask

    // Asynchronous reset applied away from the clock edge; takes effect at once.
    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_sof = 1'b0;
        #1;
        model_reset();
        chk("rst m_valid0", 128'(mv0), 128'(0));
        chk("rst rot_idx0", 128'(ri0), 128'(0));
        chk("rst m_valid2", 128'(mv2), 128'(0));
        chk("rst rot_idx2", 128'(ri2), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [63:0] lanes8;
    logic [71:0] lanes3;
    logic [95:0] r96;
    logic [63:0] held;

    initial begin
        rst = 1'b0; s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b1; d0 = '0; d2 = '0;
        lanes8 = 64'h0706050403020100;
        lanes3 = {24'hAABBCE, 24'hAABBCD, 24'hAABBCC};
        model_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("reset m_data0", 128'(md0), 128'(0));
        chk("reset m_sof0", 128'(msof0), 128'(0));
        chk("reset m_sol0", 128'(msol0), 128'(0));
        chk("reset m_eol0", 128'(meol0), 128'(0));
        chk("reset s_ready0", 128'(sr0), 128'(1));
        chk("reset m_valid0", 128'(mv0), 128'(0));
        chk("reset rot_idx0", 128'(ri0), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Straight stream of 33 beats: pass-through, rotation and full wrap.
        d0 = lanes8; d2 = lanes3; s_valid = 1'b1; m_ready = 1'b1;
        for (int b = 0; b <= 32; b++) begin
            tick();
            if (b == 0) begin
                chk("beat0 data", 128'(md0), 128'(64'h0706050403020100));
                chk("beat0 sol", 128'(msol0), 128'(1));
            end
            if (b == 3) chk("beat3 eol", 128'(meol0), 128'(1));
            if (b == 4) begin
                chk("beat4 data fwd", 128'(md0), 128'(64'h0007060504030201));
                chk("beat4 data rev", 128'(md1), 128'(64'h0605040302010007));
                chk("beat4 rot_idx", 128'(ri0), 128'(1));
            end
            if (b == 28) chk("beat28 lanes01", 128'(md0[15:0]), 128'(16'h0007));
            if (b == 32) begin
                chk("beat32 data", 128'(md0), 128'(64'h0706050403020100));
                chk("beat32 rot_idx", 128'(ri0), 128'(0));
            end
            if (b == 1) chk("c3 beat1 data", 128'(md2),
                            128'({24'hAABBCC, 24'hAABBCE, 24'hAABBCD}));
        end

        // Backpressure for three cycles with input still offered.
        held = md0;
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold data", 128'(md0), 128'(held));
            chk("hold s_ready", 128'(sr0), 128'(0));
        end
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();

        // Resync mid-frame at col 2, row 3.
        do_reset();
        s_valid = 1'b1;
        for (int k = 0; k < 14; k++) tick();
        chk("pre-sof rot_idx", 128'(ri0), 128'(3));
        s_sof = 1'b1;
        tick();
        chk("sof data", 128'(md0), 128'(64'h0706050403020100));
        chk("sof m_sof", 128'(msof0), 128'(1));
        chk("sof m_sol", 128'(msol0), 128'(1));
        chk("sof rot_idx", 128'(ri0), 128'(0));
        s_sof = 1'b0;
        tick();
        chk("post-sof sol", 128'(msol0), 128'(0));
        m_ready = 1'b0;
        tick();
        do_reset();
        m_ready = 1'b1;

        // Randomized handshakes, data and occasional frame starts.
        for (int k = 0; k < 600; k++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            s_sof   = ($urandom_range(0, 19) == 0);
            d0 = {$urandom, $urandom};
            r96 = {$urandom, $urandom, $urandom};
            d2 = r96[71:0];
            tick();
        end

        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
